// File: rtl/led_scan_ndig.sv
// Time-multiplexed common-anode seven-segment driver for DIGITS digits.
// Provides per-slot brightness, a dark guard cycle, per-digit blanking/blinking and a frame pulse.
module led_scan_ndig #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SLOT_CYCLES  = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned BW           = $clog2(SLOT_CYCLES)
) (
  input  logic                  C1K,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   Val,
  input  logic [7*DIGITS-1:0]   Char,
  input  logic [DIGITS-1:0]     Cntrl,
  input  logic [DIGITS-1:0]     Brank,
  input  logic [DIGITS-1:0]     Blink,
  input  logic [DIGITS-1:0]     DPI,
  input  logic [BW-1:0]         Bright,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            C,
  output logic                  DPO,
  output logic                  FrameSync
);

  localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BRIGHT_MAX = BW'(SLOT_CYCLES - 1);

  // Active-low a..g pattern for a hex nibble.
  function automatic logic [6:0] hexdec(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b1110010;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [SW-1:0]     slot, slot_nx;
  logic [DW-1:0]     dig, dig_nx;
  logic [FW-1:0]     frame, frame_nx;
  logic              blink_off, blink_off_nx;
  logic [BW-1:0]     on_len, on_len_nx;
  logic              slot_wrap, dig_wrap, frame_wrap;
  logic              blank;
  logic [6:0]        seg_nx;
  logic              dp_nx;
  logic [DIGITS-1:0] an_nx;

  // Counter advance and slot-0 capture values for the digit about to be shown.
  always_comb begin
    slot_wrap    = (slot == SLOT_LAST);
    dig_wrap     = slot_wrap && (dig == '0);
    frame_wrap   = dig_wrap && (frame == FRAME_LAST);
    slot_nx      = slot_wrap ? '0 : slot + SW'(1);
    dig_nx       = dig;
    if (slot_wrap) begin
      dig_nx = (dig == '0) ? DIG_LAST : dig - DW'(1);
    end
    frame_nx     = frame;
    if (dig_wrap) begin
      frame_nx = frame_wrap ? '0 : frame + FW'(1);
    end
    blink_off_nx = blink_off ^ frame_wrap;

    blank  = Brank[dig_nx] | (Blink[dig_nx] & blink_off_nx);
    seg_nx = Cntrl[dig_nx] ? Char[7*dig_nx +: 7] : hexdec(Val[4*dig_nx +: 4]);
    if (blank) begin
      seg_nx = 7'h7F;
    end
    dp_nx     = blank | ~DPI[dig_nx];
    on_len_nx = (32'(Bright) >= SLOT_CYCLES) ? BRIGHT_MAX : Bright;

    // Slot 0 stays dark, so the anode only follows the on-length captured earlier.
    an_nx = '1;
    if ((slot_nx != '0) && (32'(slot_nx) <= 32'(on_len))) begin
      an_nx[dig] = 1'b0;
    end
  end

  // State and registered pin drivers.
  always_ff @(posedge C1K or negedge RST) begin
    if (!RST) begin
      slot      <= '0;
      dig       <= DIG_LAST;
      frame     <= '0;
      blink_off <= 1'b0;
      on_len    <= '0;
      AN        <= '1;
      C         <= 7'h7F;
      DPO       <= 1'b1;
      FrameSync <= 1'b0;
    end else begin
      slot      <= slot_nx;
      dig       <= dig_nx;
      frame     <= frame_nx;
      blink_off <= blink_off_nx;
      AN        <= an_nx;
      FrameSync <= dig_wrap;
      if (slot_wrap) begin
        C      <= seg_nx;
        DPO    <= dp_nx;
        on_len <= on_len_nx;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ndig.sv
// Randomized bench for led_scan_ndig against a cycle-index reference model.
// Checks a 4-slot instance fully and a 3-slot instance for anode timing and clamping.
module tb_led_scan_ndig;

  localparam int unsigned D  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned S3 = 3;
  localparam int unsigned BF = 2;
  localparam int unsigned BW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4*D-1:0] val;
  logic [7*D-1:0] chr;
  logic [D-1:0]   cntrl, brank, blink, dpi;
  logic [BW-1:0]  bright;
  logic [D-1:0]   an, an3;
  logic [6:0]     c, c3;
  logic           dpo, dpo3, fs, fs3;

  led_scan_ndig #(.DIGITS(D), .SLOT_CYCLES(S), .BLINK_FRAMES(BF), .BW(BW)) dut (
    .C1K(clk), .RST(rst), .Val(val), .Char(chr), .Cntrl(cntrl), .Brank(brank),
    .Blink(blink), .DPI(dpi), .Bright(bright), .AN(an), .C(c), .DPO(dpo), .FrameSync(fs)
  );

  led_scan_ndig #(.DIGITS(D), .SLOT_CYCLES(S3), .BLINK_FRAMES(BF), .BW(BW)) dut3 (
    .C1K(clk), .RST(rst), .Val(val), .Char(chr), .Cntrl(cntrl), .Brank(brank),
    .Blink(blink), .DPI(dpi), .Bright(bright), .AN(an3), .C(c3), .DPO(dpo3), .FrameSync(fs3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int k;
  logic [6:0] hex_tbl [16];

  // Inputs as seen at the most recent slot start of each instance.
  logic [4*D-1:0] s_val;
  logic [7*D-1:0] s_chr;
  logic [D-1:0]   s_cntrl, s_brank, s_blink, s_dpi;
  logic [BW-1:0]  s_bright, s3_bright;
  logic           s_boff, s_valid, s3_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic logic [D-1:0] exp_an(input int kk, input int ss,
                                          input logic [BW-1:0] b, input logic valid);
    int sl, dg, on;
    sl = kk % ss;
    dg = D - 1 - ((kk / ss) % D);
    on = (int'(b) >= ss) ? ss - 1 : int'(b);
    exp_an = '1;
    if (valid && sl >= 1 && sl <= on) exp_an[dg] = 1'b0;
  endfunction

  // One clock: advance the model, snapshot at slot starts, compare all outputs.
  task automatic step();
    int dg;
    logic blanked;
    logic [6:0] ec;
    logic edp;
    @(posedge clk);
    k++;
    if (k % S == 0) begin
      s_val = val; s_chr = chr; s_cntrl = cntrl; s_brank = brank;
      s_blink = blink; s_dpi = dpi; s_bright = bright;
      s_boff = (((k / (D * S)) / BF) % 2) == 1;
      s_valid = 1'b1;
    end
    if (k % S3 == 0) begin
      s3_bright = bright;
      s3_valid = 1'b1;
    end
    #1;
    dg = D - 1 - ((k / S) % D);
    ec = 7'h7F;
    edp = 1'b1;
    if (s_valid) begin
      blanked = s_brank[dg] | (s_blink[dg] & s_boff);
      if (!blanked) begin
        ec  = s_cntrl[dg] ? s_chr[7*dg +: 7] : hex_tbl[s_val[4*dg +: 4]];
        edp = ~s_dpi[dg];
      end
    end
    check("an",  32'(an),  32'(exp_an(k, S, s_bright, s_valid)));
    check("seg", 32'(c),   32'(ec));
    check("dpo", 32'(dpo), 32'(edp));
    check("fsync", 32'(fs), 32'(k % (D * S) == 0));
    check("an3", 32'(an3), 32'(exp_an(k, S3, s3_bright, s3_valid)));
    check("fsync3", 32'(fs3), 32'(k % (D * S3) == 0));
  endtask

  // Assert reset mid-slot, check the asynchronous dark state, then release on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(c), 32'h7F);
    check("rst_dpo", 32'(dpo), 32'h1);
    check("rst_fsync", 32'(fs), 32'h0);
    check("rst_an3", 32'(an3), 32'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    s_valid = 1'b0;
    s3_valid = 1'b0;
  endtask

  initial begin
    hex_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};
    k = 0;
    s_valid = 1'b0; s3_valid = 1'b0; s_boff = 1'b0;
    s_val = '0; s_chr = '1; s_cntrl = '0; s_brank = '0; s_blink = '0; s_dpi = '0;
    s_bright = '0; s3_bright = '0;
    val = 16'h1234; chr = '1; cntrl = '0; brank = '0; blink = '0; dpi = '0; bright = 2'd3;

    // Scan order, guard cycle and mid-slot input change.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step();
      if (k == 17) begin
        check("scan_d3_an", 32'(an), 32'b0111);
        check("scan_d3_seg", 32'(c), 32'b1001111);
      end
      if (k == 20) check("guard_an", 32'(an), 32'hF);
      if (k == 21) begin
        check("scan_d2_an", 32'(an), 32'b1011);
        check("scan_d2_seg", 32'(c), 32'b0010010);
      end
      if (k == 34) val[15:12] = 4'h8;
      if (k == 35) check("midslot_hold", 32'(c), 32'b1001111);
      if (k == 49) check("midslot_new", 32'(c), 32'b0000000);
    end

    // Char override, blanking, decimal point and blinking of digit 3.
    do_reset();
    cntrl = 4'b0010; chr[13:7] = 7'b1111110; brank = 4'b0001; dpi = 4'b0100;
    blink = 4'b1000; bright = 2'd2;
    for (int i = 0; i < 160; i++) step();

    // Dark and minimum brightness.
    bright = 2'd0;
    for (int i = 0; i < 40; i++) step();
    bright = 2'd1;
    for (int i = 0; i < 40; i++) step();

    // Randomized input churn, including changes in the middle of slots.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step();
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(6))
          0: val = 16'($urandom);
          1: chr = 28'($urandom);
          2: cntrl = 4'($urandom);
          3: brank = 4'($urandom) & 4'($urandom);
          4: blink = 4'($urandom);
          5: dpi = 4'($urandom);
          default: bright = 2'($urandom);
        endcase
      end
      if (i == 1000) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
